// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand-bit bundle between a host, the two operand shift
// registers and the serial adder sequencer.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             carry_in;
  logic             ready;
  logic             done;
  logic             sr_load;
  logic             sr_enable;
  logic             a_bit;
  logic             b_bit;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, carry_in, a_bit, b_bit,
    input  ready, done, sr_load, sr_enable, sum, carry_out, overflow
  );

  modport slave (
    input  start, carry_in, a_bit, b_bit,
    output ready, done, sr_load, sr_enable, sum, carry_out, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Serial adder sequencer: loads both operand shift registers, then adds one bit
// per cycle LSB first. Define SERIAL_ADDER_OVF_EN to compute signed overflow.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic             c_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             co_reg;

  logic ready_dec, done_dec, load_dec, enable_dec;
  logic s_bit, maj, last;

  assign s_bit = bus.a_bit ^ bus.b_bit ^ c_reg;
  assign maj   = (bus.a_bit & bus.b_bit) | (bus.a_bit & c_reg) | (bus.b_bit & c_reg);
  assign last  = (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready_dec  = 1'b0;
    done_dec   = 1'b0;
    load_dec   = 1'b0;
    enable_dec = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_dec = 1'b1;
        if (bus.start) state_next = LOAD;
      end
      LOAD: begin
        load_dec   = 1'b1;
        enable_dec = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        enable_dec = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done_dec   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit datapath: carry flop, result shift-in from the top, bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      c_reg   <= 1'b0;
      sum_reg <= '0;
      co_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            c_reg   <= bus.carry_in;
            sum_reg <= '0;
          end
        end
        LOAD: cnt_reg <= '0;
        ADD: begin
          c_reg   <= maj;
          sum_reg <= {s_bit, sum_reg[WIDTH-1:1]};
          cnt_reg <= cnt_reg + 1'b1;
          if (last) co_reg <= maj;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;

  // Carry into the MSB is c_reg during the last ADD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   ovf_reg <= 1'b0;
    else if (state_reg == IDLE && bus.start)   ovf_reg <= 1'b0;
    else if (state_reg == ADD && last)         ovf_reg <= c_reg ^ maj;
  end

  assign bus.overflow = ovf_reg;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.ready     = ready_dec;
  assign bus.done      = done_dec;
  assign bus.sr_load   = load_dec;
  assign bus.sr_enable = enable_dec;
  assign bus.sum       = sum_reg;
  assign bus.carry_out = co_reg;
endmodule
